// File: rtl/vga_row_fetcher.sv
// Row prefetch engine: double-buffers one display row per colour, swapping on each line request.
// Optional feature: define ROWFETCH_UNDERRUN_CNT_EN to add a saturating underrun_count output.
module vga_row_fetcher #(
    parameter int H_PIXELS = 640,
    parameter int V_LINES  = 480,
    parameter int ADDR_W   = 19,
    parameter int MAX_OUT  = 4
) (
    input  logic                  clk_25,
    input  logic                  reset_n,
    input  logic [8:0]            currentRow,
    input  logic                  requestRow,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_rd,
    input  logic                  mem_ready,
    input  logic                  mem_valid,
    input  logic [11:0]           mem_rdata,
    output logic [4*H_PIXELS-1:0] rowbuffer_r,
    output logic [4*H_PIXELS-1:0] rowbuffer_g,
    output logic [4*H_PIXELS-1:0] rowbuffer_b,
    output logic                  fetch_busy,
    output logic                  underrun,
`ifdef ROWFETCH_UNDERRUN_CNT_EN
    output logic [15:0]           underrun_count,
`endif
    output logic [1:0]            fsm_state
);

    localparam int COL_W = $clog2(H_PIXELS + 1);
    localparam int BIT_W = $clog2(4 * H_PIXELS);
    localparam int OUT_W = 4;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]            state;
    logic                  req_q;
    logic [COL_W-1:0]      col;
    logic [COL_W-1:0]      wcol;
    logic [OUT_W-1:0]      outstanding;
    logic [ADDR_W-1:0]     base;
    logic [ADDR_W-1:0]     pend_base;
    logic [4*H_PIXELS-1:0] back_r, back_g, back_b;

    logic                  req_edge;
    logic                  accept;
    logic                  ret;
    logic                  write_en;
    logic [8:0]            target;
    logic [ADDR_W-1:0]     tgt_base;
    logic [ADDR_W-1:0]     flush_base;
    logic [BIT_W-1:0]      wbit;

    // 640 = 512 + 128, so the default width needs only two shifts and an add.
    function automatic logic [ADDR_W-1:0] row_base(input logic [8:0] t);
        if (H_PIXELS == 640)
            return (ADDR_W'(t) << 9) + (ADDR_W'(t) << 7);
        else
            return ADDR_W'(t) * ADDR_W'(H_PIXELS);
    endfunction

    assign req_edge   = requestRow & ~req_q;
    assign target     = (currentRow < 9'(V_LINES - 1)) ? currentRow + 9'd1 : 9'd0;
    assign tgt_base   = row_base(target);
    assign flush_base = req_edge ? tgt_base : pend_base;

    assign mem_rd     = (state == S_FETCH) && (outstanding < OUT_W'(MAX_OUT)) &&
                        (col < COL_W'(H_PIXELS));
    assign mem_addr   = base + ADDR_W'(col);
    assign accept     = mem_rd & mem_ready;
    assign ret        = mem_valid & (outstanding != '0);
    assign write_en   = ret && ((state == S_FETCH) || (state == S_DRAIN)) &&
                        (wcol < COL_W'(H_PIXELS));
    assign wbit       = BIT_W'({wcol, 2'b00});
    assign fetch_busy = (state != S_IDLE);
    assign fsm_state  = state;

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            req_q       <= 1'b0;
            col         <= '0;
            wcol        <= '0;
            outstanding <= '0;
            base        <= '0;
            pend_base   <= '0;
            underrun    <= 1'b0;
            back_r      <= '0;
            back_g      <= '0;
            back_b      <= '0;
            rowbuffer_r <= '0;
            rowbuffer_g <= '0;
            rowbuffer_b <= '0;
        end else begin
            req_q    <= requestRow;
            underrun <= 1'b0;

            case ({accept, ret})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase

            // Returns belonging to an aborted fetch are dropped while flushing.
            if (write_en) begin
                back_r[wbit +: 4] <= mem_rdata[11:8];
                back_g[wbit +: 4] <= mem_rdata[7:4];
                back_b[wbit +: 4] <= mem_rdata[3:0];
                wcol              <= wcol + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (req_edge) begin
                        rowbuffer_r <= back_r;
                        rowbuffer_g <= back_g;
                        rowbuffer_b <= back_b;
                        base        <= tgt_base;
                        col         <= '0;
                        wcol        <= '0;
                        state       <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (req_edge) begin
                        underrun  <= 1'b1;
                        pend_base <= tgt_base;
                        state     <= S_FLUSH;
                    end else if (accept) begin
                        col <= col + 1'b1;
                        if (col == COL_W'(H_PIXELS - 1))
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (req_edge) begin
                        underrun  <= 1'b1;
                        pend_base <= tgt_base;
                        state     <= S_FLUSH;
                    end else if (wcol == COL_W'(H_PIXELS)) begin
                        state <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (req_edge) begin
                        underrun  <= 1'b1;
                        pend_base <= tgt_base;
                    end
                    if (outstanding == '0) begin
                        base  <= flush_base;
                        col   <= '0;
                        wcol  <= '0;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ROWFETCH_UNDERRUN_CNT_EN
    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n)
            underrun_count <= '0;
        else if (underrun && (underrun_count != 16'hFFFF))
            underrun_count <= underrun_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_vga_row_fetcher.sv
// Self-checking bench for vga_row_fetcher: memory model returns word = addr[11:0],
// scoreboard of expected read addresses, front-buffer checks after every swap.
module tb_vga_row_fetcher;

    localparam int H      = 640;
    localparam int ADDR_W = 19;
    localparam int W      = 4 * H;

    logic              clk_25 = 1'b0;
    logic              reset_n = 1'b0;
    logic [8:0]        currentRow = '0;
    logic              requestRow = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic              mem_ready = 1'b0;
    logic              mem_valid = 1'b0;
    logic [11:0]       mem_rdata = '0;
    logic [W-1:0]      rowbuffer_r, rowbuffer_g, rowbuffer_b;
    logic              fetch_busy;
    logic              underrun;
    logic [1:0]        fsm_state;
`ifdef ROWFETCH_UNDERRUN_CNT_EN
    logic [15:0]       underrun_count;
`endif

    vga_row_fetcher dut (
        .clk_25      (clk_25),
        .reset_n     (reset_n),
        .currentRow  (currentRow),
        .requestRow  (requestRow),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_ready   (mem_ready),
        .mem_valid   (mem_valid),
        .mem_rdata   (mem_rdata),
        .rowbuffer_r (rowbuffer_r),
        .rowbuffer_g (rowbuffer_g),
        .rowbuffer_b (rowbuffer_b),
        .fetch_busy  (fetch_busy),
        .underrun    (underrun),
`ifdef ROWFETCH_UNDERRUN_CNT_EN
        .underrun_count (underrun_count),
`endif
        .fsm_state   (fsm_state)
    );

    // Clock / reset
    always #20 clk_25 = ~clk_25;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Memory model and address scoreboard
    typedef struct {
        logic [ADDR_W-1:0] a;
        longint            due;
    } rd_t;

    rd_t               pend[$];
    logic [ADDR_W-1:0] exp_q[$];
    longint            cyc = 0;
    int                lat = 2;
    bit                rand_ready = 1'b0;
    int                n_acc = 0;
    int                n_ret = 0;
    int                max_out = 0;
    int                row_acc = 0;
    bit                chk_refetch = 1'b0;
    int                n_underrun = 0;
    int                exp_underrun = 0;

    always @(posedge clk_25) begin
        rd_t r;
        int  outs;
        #1;
        cyc++;
        if (!reset_n) begin
            pend.delete();
            mem_valid = 1'b0;
            mem_ready = 1'b0;
            n_acc = 0;
            n_ret = 0;
        end else begin
            outs = n_acc - n_ret;
            mem_valid = 1'b0;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                r = pend.pop_front();
                mem_valid = 1'b1;
                mem_rdata = r.a[11:0];
                n_ret++;
            end
            mem_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (mem_rd && mem_ready) begin
                if (chk_refetch) begin
                    check_eq("refetch_after_drain", outs, 0);
                    chk_refetch = 1'b0;
                end
                check_eq("addr_q_has_entry", exp_q.size() != 0, 1);
                if (exp_q.size() != 0)
                    check_eq("addr", mem_addr, exp_q.pop_front());
                pend.push_back('{mem_addr, cyc + lat});
                n_acc++;
                row_acc++;
                if (n_acc - n_ret > max_out)
                    max_out = n_acc - n_ret;
            end
        end
    end

    always @(negedge clk_25)
        if (reset_n && underrun)
            n_underrun++;

    function automatic logic [W-1:0] exp_row(input int row, input int sh);
        logic [W-1:0] v;
        v = '0;
        if (row >= 0)
            for (int c = 0; c < H; c++) begin
                int a;
                a = row * H + c;
                v[4*c +: 4] = 4'((a >> sh) & 15);
            end
        return v;
    endfunction

    task automatic check_front(input string tag, input int row);
        check_eq({tag, "_r"}, rowbuffer_r == exp_row(row, 8), 1);
        check_eq({tag, "_g"}, rowbuffer_g == exp_row(row, 4), 1);
        check_eq({tag, "_b"}, rowbuffer_b == exp_row(row, 0), 1);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_mem_rd"}, mem_rd, 0);
        check_eq({tag, "_mem_addr"}, mem_addr, 0);
        check_eq({tag, "_busy"}, fetch_busy, 0);
        check_eq({tag, "_underrun"}, underrun, 0);
        check_eq({tag, "_state"}, fsm_state, 0);
        check_front(tag, -1);
    endtask

    // Driver: raise requestRow for one cycle; leaves the caller on the negedge after the swap edge.
    task automatic issue_req(input int cur, input int tgt, input bit abort);
        if (abort) begin
            exp_q.delete();
            chk_refetch = 1'b1;
            exp_underrun++;
        end
        for (int c = 0; c < H; c++)
            exp_q.push_back(ADDR_W'(tgt * H + c));
        row_acc = 0;
        currentRow = 9'(cur);
        requestRow = 1'b1;
        @(negedge clk_25);
        requestRow = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int busy);
        busy = 0;
        while (fetch_busy && busy < 20000) begin
            busy++;
            @(negedge clk_25);
        end
        check_eq({tag, "_done"}, fetch_busy, 0);
        check_eq({tag, "_addrs_left"}, exp_q.size(), 0);
    endtask

    task automatic wait_col(input string tag, input int n);
        int t;
        t = 0;
        while (row_acc < n && t < 5000) begin
            t++;
            @(negedge clk_25);
        end
        check_eq({tag, "_reached"}, row_acc >= n, 1);
    endtask

    // Start a fetch of front_row+?, abort it at column 'at' with a request for new_tgt.
    task automatic mid_abort(input string tag, input int cur1, input int tgt1, input int prev_row,
                             input int cur2, input int tgt2, input int at);
        int b;
        int u0;
        issue_req(cur1, tgt1, 1'b0);
        check_front({tag, "_swap"}, prev_row);
        wait_col(tag, at);
        u0 = n_underrun;
        issue_req(cur2, tgt2, 1'b1);
        check_front({tag, "_front_kept"}, prev_row);
        check_eq({tag, "_flush_no_rd"}, mem_rd, 0);
        wait_idle(tag, b);
        check_eq({tag, "_underrun_once"}, n_underrun - u0, 1);
    endtask

    initial begin
        int b;
        reset_n = 1'b0;
        repeat (3) @(negedge clk_25);
        check_zero("in_reset");
        reset_n = 1'b1;
        repeat (3) @(negedge clk_25);
        check_zero("post_reset");

        // Reset in the middle of a fetch.
        issue_req(4, 5, 1'b0);
        repeat (40) @(negedge clk_25);
        check_eq("pre_reset_busy", fetch_busy, 1);
        reset_n = 1'b0;
        #1;
        check_zero("mid_reset");
        exp_q.delete();
        @(negedge clk_25);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_25);
        check_zero("after_release");

        // L=2, always ready: row 10 (addresses 6400..7039).
        issue_req(9, 10, 1'b0);
        check_front("swap_cleared", -1);
        check_eq("first_rd", mem_rd, 1);
        check_eq("first_addr", mem_addr, 6400);
        wait_idle("row10", b);
        check_eq("row10_busy_cycles", b, 643);

        issue_req(479, 0, 1'b0);
        check_front("swap_row10", 10);
        wait_idle("row479", b);
        check_eq("row479_busy_cycles", b, 643);

        issue_req(500, 0, 1'b0);
        check_front("swap_row0a", 0);
        wait_idle("row500", b);

        // L=7, random ready.
        lat = 7;
        rand_ready = 1'b1;
        max_out = 0;
        issue_req(99, 100, 1'b0);
        check_front("swap_row0b", 0);
        wait_idle("row100", b);

        mid_abort("abort1", 199, 200, 100, 299, 300, 300);

        issue_req(309, 310, 1'b0);
        check_front("swap_row300", 300);
        wait_idle("row310", b);
        check_eq("max_outstanding", max_out, 4);

`ifdef ROWFETCH_UNDERRUN_CNT_EN
        check_eq("ucnt_1", underrun_count, 1);
        mid_abort("abort2", 319, 320, 310, 329, 330, 100);
        mid_abort("abort3", 339, 340, 330, 349, 350, 200);
        check_eq("ucnt_3", underrun_count, 3);
        force dut.underrun_count = 16'hFFFF;
        @(negedge clk_25);
        release dut.underrun_count;
        mid_abort("abort4", 359, 360, 350, 369, 370, 50);
        check_eq("ucnt_sat", underrun_count, 16'hFFFF);
`endif

        check_eq("underrun_total", n_underrun, exp_underrun);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(40 * 100000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
